// File: rtl/fifo_chk_pkg.sv
// Shared definitions for the FIFO scoreboard checker: error-vector bit map,
// vector width and a saturating counter helper.
package fifo_chk_pkg;

  localparam int ERR_W = 8;

  // Bit position of each checked FIFO response inside err_vec
  typedef enum logic [2:0] {
    CHK_DOUT  = 3'd0,
    CHK_WACK  = 3'd1,
    CHK_OVF   = 3'd2,
    CHK_UDF   = 3'd3,
    CHK_FULL  = 3'd4,
    CHK_EMPTY = 3'd5,
    CHK_AF    = 3'd6,
    CHK_AE    = 3'd7
  } chk_idx_e;

  // Increment v unless it already holds the all-ones value of a w-bit counter
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (64'd1 << w) - 64'd1;
    return (v == max_v) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/fifo_ref_model.sv
// Cycle-accurate reference model of the FIFO under check. Produces the
// responses the FIFO should present in the current cycle.
module fifo_ref_model #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_TH      = FIFO_DEPTH - 1,
  parameter int AE_TH      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] exp_dout,
  output logic                  exp_rd_vld,
  output logic                  exp_wr_ack,
  output logic                  exp_ovf,
  output logic                  exp_udf,
  output logic                  exp_full,
  output logic                  exp_empty,
  output logic                  exp_af,
  output logic                  exp_ae
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  rd_vld_q, rd_vld_d;
  logic                  wack_q, wack_d, ovf_q, ovf_d, udf_q, udf_d;
  logic                  do_wr, do_rd;

  // Next-state: a write needs room, a read needs data. With both requested an
  // empty FIFO only writes and a full one only reads, so the rejected half of
  // a simultaneous request does not raise overflow/underflow.
  always_comb begin
    do_wr    = wr_en && (cnt_q != DEPTH_C);
    do_rd    = rd_en && (cnt_q != '0);
    wptr_d   = do_wr ? wptr_q + 1'b1 : wptr_q;
    rptr_d   = do_rd ? rptr_q + 1'b1 : rptr_q;
    cnt_d    = cnt_q + CW'(do_wr) - CW'(do_rd);
    dout_d   = do_rd ? mem_q[rptr_q] : dout_q;
    rd_vld_d = do_rd;
    wack_d   = do_wr;
    ovf_d    = wr_en && !rd_en && (cnt_q == DEPTH_C);
    udf_d    = rd_en && !wr_en && (cnt_q == '0);
  end

  // Pointers, occupancy and registered expected responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      rd_vld_q <= 1'b0;
      wack_q   <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      rd_vld_q <= rd_vld_d;
      wack_q   <= wack_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is not reset; stale words are unreachable once pointers clear
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= data_in;
  end

  assign exp_dout   = dout_q;
  assign exp_rd_vld = rd_vld_q;
  assign exp_wr_ack = wack_q;
  assign exp_ovf    = ovf_q;
  assign exp_udf    = udf_q;
  assign exp_full   = (cnt_q == DEPTH_C);
  assign exp_empty  = (cnt_q == '0);
  assign exp_af     = (cnt_q == CW'(AF_TH));
  assign exp_ae     = (cnt_q == CW'(AE_TH));

endmodule

// File: rtl/fifo_scoreboard_checker.sv
// Scoreboard checker: compares observed FIFO responses against the reference
// model each enabled cycle, reports masked mismatches and keeps statistics.
module fifo_scoreboard_checker
  import fifo_chk_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_TH      = FIFO_DEPTH - 1,
  parameter int AE_TH      = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic                  wr_ack,
  input  logic                  overflow,
  input  logic                  underflow,
  input  logic                  full,
  input  logic                  empty,
  input  logic                  almostfull,
  input  logic                  almostempty,
  input  logic                  check_en,
  input  logic [7:0]            err_mask,
  output logic                  err_flag,
  output logic [7:0]            err_vec,
  output logic [7:0]            first_err_vec,
  output logic [CNT_WIDTH-1:0]  check_count,
  output logic [CNT_WIDTH-1:0]  error_count,
  output logic [CNT_WIDTH-1:0]  first_err_cycle
);

  logic [DATA_WIDTH-1:0] exp_dout;
  logic exp_rd_vld, exp_wr_ack, exp_ovf, exp_udf;
  logic exp_full, exp_empty, exp_af, exp_ae;

  fifo_ref_model #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .AF_TH      (AF_TH),
    .AE_TH      (AE_TH)
  ) u_model (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .data_in    (data_in),
    .exp_dout   (exp_dout),
    .exp_rd_vld (exp_rd_vld),
    .exp_wr_ack (exp_wr_ack),
    .exp_ovf    (exp_ovf),
    .exp_udf    (exp_udf),
    .exp_full   (exp_full),
    .exp_empty  (exp_empty),
    .exp_af     (exp_af),
    .exp_ae     (exp_ae)
  );

  logic [ERR_W-1:0]     mis;
  logic [ERR_W-1:0]     err_vec_q, err_vec_d, first_err_vec_q, first_err_vec_d;
  logic                 err_flag_q, err_flag_d;
  logic [CNT_WIDTH-1:0] check_count_q, check_count_d;
  logic [CNT_WIDTH-1:0] error_count_q, error_count_d;
  logic [CNT_WIDTH-1:0] first_err_cycle_q, first_err_cycle_d;

  // Compare against pre-update model values; data only after a model read
  always_comb begin
    mis                = '0;
    mis[CHK_DOUT]      = exp_rd_vld && (data_out != exp_dout);
    mis[CHK_WACK]      = wr_ack      != exp_wr_ack;
    mis[CHK_OVF]       = overflow    != exp_ovf;
    mis[CHK_UDF]       = underflow   != exp_udf;
    mis[CHK_FULL]      = full        != exp_full;
    mis[CHK_EMPTY]     = empty       != exp_empty;
    mis[CHK_AF]        = almostfull  != exp_af;
    mis[CHK_AE]        = almostempty != exp_ae;
    err_vec_d          = check_en ? (mis & ~err_mask) : '0;
    check_count_d      = check_count_q;
    error_count_d      = error_count_q;
    err_flag_d         = err_flag_q;
    first_err_vec_d    = first_err_vec_q;
    first_err_cycle_d  = first_err_cycle_q;
    if (check_en) begin
      check_count_d = CNT_WIDTH'(sat_inc(64'(check_count_q), CNT_WIDTH));
      if (|err_vec_d) begin
        error_count_d = CNT_WIDTH'(sat_inc(64'(error_count_q), CNT_WIDTH));
        if (!err_flag_q) begin
          err_flag_d        = 1'b1;
          first_err_vec_d   = err_vec_d;
          first_err_cycle_d = check_count_q;
        end
      end
    end
  end

  // Result and statistics registers; reset also suppresses any compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_vec_q         <= '0;
      err_flag_q        <= 1'b0;
      first_err_vec_q   <= '0;
      check_count_q     <= '0;
      error_count_q     <= '0;
      first_err_cycle_q <= '0;
    end else begin
      err_vec_q         <= err_vec_d;
      err_flag_q        <= err_flag_d;
      first_err_vec_q   <= first_err_vec_d;
      check_count_q     <= check_count_d;
      error_count_q     <= error_count_d;
      first_err_cycle_q <= first_err_cycle_d;
    end
  end

  assign err_vec         = err_vec_q;
  assign err_flag        = err_flag_q;
  assign first_err_vec   = first_err_vec_q;
  assign check_count     = check_count_q;
  assign error_count     = error_count_q;
  assign first_err_cycle = first_err_cycle_q;

endmodule
